// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, instruction classes and loader FSM
// encodings used by the controller and the program loader.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] IMM    = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    CLASS_R       = 3'd0,
    CLASS_LOAD    = 3'd1,
    CLASS_STORE   = 3'd2,
    CLASS_BRANCH  = 3'd3,
    CLASS_IMM     = 3'd4,
    CLASS_JAL     = 3'd5,
    CLASS_JALR    = 3'd6,
    CLASS_ILLEGAL = 3'd7
  } instr_class_t;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t ST_IDLE  = 2'd0;
  localparam loader_state_t ST_LOAD  = 2'd1;
  localparam loader_state_t ST_FLUSH = 2'd2;
  localparam loader_state_t ST_DONE  = 2'd3;

  // True when value is representable as a two's-complement number of 'bits' width,
  // i.e. every bit from bits-1 upward matches the sign bit.
  function automatic logic fits_signed(input logic [31:0] value, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= bits - 1 && value[i] != value[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder: packs decoded fields back into a 32-bit word and
// flags immediates that the selected format cannot represent.
module instr_encode
  import riscv_pkg::*;
(
  input  instr_class_t InClass,
  input  logic [4:0]   Rd,
  input  logic [4:0]   Rs1,
  input  logic [4:0]   Rs2,
  input  logic [2:0]   Funct3,
  input  logic [6:0]   Funct7,
  input  logic [31:0]  Imm,
  output logic [31:0]  Word,
  output logic         RangeErr
);

  logic is_shift;

  assign is_shift = (Funct3 == 3'b001) || (Funct3 == 3'b101);

  always_comb begin
    Word     = '0;
    RangeErr = 1'b0;
    case (InClass)
      CLASS_R: begin
        Word = {Funct7, Rs2, Rs1, Funct3, Rd, R_TYPE};
      end
      CLASS_LOAD: begin
        Word     = {Imm[11:0], Rs1, Funct3, Rd, LW};
        RangeErr = !fits_signed(Imm, 12);
      end
      // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
      CLASS_IMM: begin
        if (is_shift) Word = {Funct7, Imm[4:0], Rs1, Funct3, Rd, IMM};
        else          Word = {Imm[11:0], Rs1, Funct3, Rd, IMM};
        RangeErr = !fits_signed(Imm, 12);
      end
      CLASS_JALR: begin
        Word     = {Imm[11:0], Rs1, 3'b000, Rd, JALR};
        RangeErr = !fits_signed(Imm, 12);
      end
      CLASS_STORE: begin
        Word     = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], SW};
        RangeErr = !fits_signed(Imm, 12);
      end
      CLASS_BRANCH: begin
        Word     = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], BR};
        RangeErr = !fits_signed(Imm, 13) || Imm[0];
      end
      CLASS_JAL: begin
        Word     = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, JAL};
        RangeErr = !fits_signed(Imm, 21) || Imm[0];
      end
      default: begin
        RangeErr = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Boot/test loader: accepts decoded field tuples over valid/ready and writes the
// encoded words to sequential instruction-memory addresses from BASE_ADDR.
module imem_program_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        InClass,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [2:0]        Funct3,
  input  logic [6:0]        Funct7,
  input  logic [31:0]       Imm,
  input  logic              InLast,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W:0]   Count
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  loader_state_t     state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              err_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       enc_word;
  logic              range_err;
  logic              xfer;

  instr_encode u_encode (
    .InClass  (instr_class_t'(InClass)),
    .Rd       (Rd),
    .Rs1      (Rs1),
    .Rs2      (Rs2),
    .Funct3   (Funct3),
    .Funct7   (Funct7),
    .Imm      (Imm),
    .Word     (enc_word),
    .RangeErr (range_err)
  );

  assign InReady = (state == ST_LOAD);
  assign xfer    = InValid && InReady;

  // The output register holds a write for exactly one cycle; a full pointer
  // still takes its word but ends the session rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_ptr      <= BASE_PTR;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_PTR;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state   <= ST_LOAD;
            err_q   <= 1'b0;
            count_q <= '0;
            wr_ptr  <= BASE_PTR;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (range_err) begin
              err_q <= 1'b1;
              if (InLast) state <= ST_FLUSH;
            end else begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wr_ptr;
              mem_wdata_q <= enc_word;
              count_q     <= count_q + 1'b1;
              if (wr_ptr == LAST_PTR) begin
                err_q <= 1'b1;
                state <= ST_FLUSH;
              end else begin
                wr_ptr <= wr_ptr + 1'b1;
                if (InLast) state <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign MemWE    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign Busy     = (state != ST_IDLE);
  assign Done     = (state == ST_DONE);
  assign Err      = err_q;
  assign Count    = count_q;

endmodule
